e603_subsys_ram_icb1to2_split: RTL and testbench
================================================

Name: e603_subsys_ram_icb1to2_split

Overview:
Upstream neighbour of the subsystem RAM block. Takes the single 64-bit ICB master port from the BIU and decodes each command address into the IRAM window, the DRAM window, or unmapped space. Mapped commands go to the matching biu2iram_* or biu2dram_* 16-bit ICB port. Unmapped commands receive a locally generated error response. An in-order outstanding FIFO records the destination of each accepted command, so responses return to the master in command order.

Parameters:
- AW, 32: master-side address width.
- IRAM_BASE, 32'h8000_0000: IRAM window base; 64 KB aligned.
- DRAM_BASE, 32'h9000_0000: DRAM window base; 64 KB aligned.
- OUTS_NUM, 4: outstanding FIFO depth, power of 2, range 2..16.
- OUTS_CNT_W, 3: occupancy counter width, equal to log2(OUTS_NUM)+1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset.
- i_icb_cmd_valid/ready  in/out  1  master command handshake.
- i_icb_cmd_addr  in  AW  byte address.
- i_icb_cmd_read  in  1  1 = read.
- i_icb_cmd_wdata  in  64  write data.
- i_icb_cmd_wmask  in  8  byte mask.
- i_icb_rsp_valid/ready  out/in  1  master response handshake.
- i_icb_rsp_err  out  1  error flag.
- i_icb_rsp_rdata  out  64  read data.
- biu2iram_icb_cmd_valid/ready, _addr[15:0], _read, _wdata[63:0], _wmask[7:0]  out/in  IRAM command channel.
- biu2iram_icb_rsp_valid/ready, _err, _rdata[63:0]  in/out  IRAM response channel.
- biu2dram_* (same set as biu2iram_*)  DRAM port.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state:
  - FIFO empty, occupancy 0.
  - i_icb_rsp_valid = 0.
  - biu2*_icb_cmd_valid = 0.
  - biu2*_icb_rsp_ready = 0.
  - i_icb_cmd_ready = 0 while rst_n is low.
- Decode (combinational):
  - hit_i when addr[AW-1:16] == IRAM_BASE[AW-1:16].
  - hit_d when addr[AW-1:16] == DRAM_BASE[AW-1:16].
  - Otherwise the command is unmapped (ERR).
  - The forwarded address is addr[15:0]; read, wdata and wmask pass through unchanged.
- Command path (zero added latency):
  - biu2X_icb_cmd_valid = i_icb_cmd_valid & hit_X & !full.
  - i_icb_cmd_ready = !full & (hit_i ? iram_ready : hit_d ? dram_ready : 1).
  - full is registered occupancy == OUTS_NUM. There is no push-while-full even if a pop occurs the same cycle, which keeps ready paths free of rsp_ready.
- FIFO:
  - On master command handshake, push a 2-bit destination tag: 0 = IRAM, 1 = DRAM, 2 = ERR.
  - On master response handshake, pop the head entry.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Read/write pointers wrap modulo OUTS_NUM.
- Response routing by head tag; only the head destination is listened to.
  - IRAM: i_icb_rsp_valid = iram_rsp_valid. iram_rsp_ready = i_icb_rsp_ready. err and rdata pass through from IRAM.
  - DRAM: same, from the DRAM port.
  - ERR: i_icb_rsp_valid = 1 while the head is ERR, so the earliest response comes one cycle after acceptance. err = 1, rdata = 0.
  - Empty FIFO: i_icb_rsp_valid = 0 and both biu2*_icb_rsp_ready = 0.
  - A non-head destination's rsp_ready is held 0. Its response stalls until that destination reaches the head, which guarantees in-order return.
- Response latency: downstream ports have ≥1-cycle response latency. A response on an empty FIFO is not accepted, and a same-cycle push-then-respond bypass is not supported.
- Reset mid-transaction: FIFO state is discarded. Downstream blocks share rst_n, so no orphan responses exist.
- Addresses are in the 64-bit data domain. The lower 3 address bits are forwarded as-is and the SRAM controller ignores them.

Decomposition:
- Shared package holds the destination tag constants TAG_IRAM = 2'd0, TAG_DRAM = 2'd1, TAG_ERR = 2'd2 and the window-size constant RAM_WIN_AW = 16.
- One natural sub-module: e603_subsys_ram_outs_fifo, a generic synchronous FIFO with parameters for width and depth, exposing push, pop, full, empty and head.

Test Plan:
- Single read to 0x8000_0010 with IRAM rsp 0xDEAD_BEEF_0123_4567 → biu2iram_icb_cmd_addr = 0x0010, master sees rdata 0xDEAD_BEEF_0123_4567 with err = 0; DRAM untouched.
- Write to 0x9000_FFF8 with wmask 0x0F → biu2dram_icb_cmd_addr = 0xFFF8, wmask 0x0F forwarded; response err = 0.
- Read to 0xA000_0000 → no downstream valid; i_icb_rsp_valid asserted the cycle after acceptance with err = 1 and rdata = 0.
- Order check: back-to-back IRAM, DRAM, IRAM, with DRAM responding first → DRAM response held (dram rsp_ready = 0) until the first IRAM response pops; master receives responses in order IRAM, DRAM, IRAM.
- Fill: 4 commands to IRAM with rsp_valid held 0 → i_icb_cmd_ready = 0 on the 5th command. After one response pops, ready returns the next cycle.
- Assert rst_n low with 3 outstanding → all valids drop immediately. After release, FIFO empty, and a new read to 0x8000_0000 completes normally.

Source files
------------

// File: rtl/e603_subsys_ram_icb1to2_split_pkg.sv
// Shared definitions for the BIU-to-subsystem-RAM ICB splitter:
// destination tags stored in the outstanding FIFO and the RAM window size.
package e603_subsys_ram_icb1to2_split_pkg;

    // Each RAM window covers 64 KB, so the low 16 address bits are forwarded
    // and the bits above them select the window.
    localparam int RAM_WIN_AW = 16;

    // Destination of an accepted command, recorded in command order.
    typedef logic [1:0] dest_tag_t;

    localparam dest_tag_t TAG_IRAM = 2'd0;
    localparam dest_tag_t TAG_DRAM = 2'd1;
    localparam dest_tag_t TAG_ERR  = 2'd2;

    // Turn the two window hits into a destination tag. IRAM wins if a
    // misconfiguration ever makes both windows overlap.
    function automatic dest_tag_t decode_dest(input logic hit_i, input logic hit_d);
        if (hit_i) begin
            return TAG_IRAM;
        end
        if (hit_d) begin
            return TAG_DRAM;
        end
        return TAG_ERR;
    endfunction

endpackage

// File: rtl/e603_subsys_ram_outs_fifo.sv
// Generic synchronous FIFO used to remember the destination of every
// outstanding command. Depth must be a power of two so the pointers wrap
// naturally. Pushing while full and popping while empty are ignored.
module e603_subsys_ram_outs_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_en;
    logic             pop_en;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage, written at the tail on every accepted push.
    // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/e603_subsys_ram_icb1to2_split.sv
// Splits the BIU's single 64-bit ICB master port into the IRAM and DRAM ICB
// ports of the subsystem RAM. Commands are decoded by address window and
// forwarded with no added latency; unmapped commands are answered locally
// with an error. An outstanding FIFO of destination tags keeps responses in
// command order: only the destination at the head may return a response.
module e603_subsys_ram_icb1to2_split
    import e603_subsys_ram_icb1to2_split_pkg::*;
#(
    parameter int          AW         = 32,
    parameter logic [AW-1:0] IRAM_BASE = 32'h8000_0000,
    parameter logic [AW-1:0] DRAM_BASE = 32'h9000_0000,
    parameter int          OUTS_NUM   = 4,
    parameter int          OUTS_CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,

    // Master side (from the BIU)
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [AW-1:0] i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    input  logic [63:0]   i_icb_cmd_wdata,
    input  logic [7:0]    i_icb_cmd_wmask,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          i_icb_rsp_err,
    output logic [63:0]   i_icb_rsp_rdata,

    // IRAM port
    output logic          biu2iram_icb_cmd_valid,
    input  logic          biu2iram_icb_cmd_ready,
    output logic [15:0]   biu2iram_icb_cmd_addr,
    output logic          biu2iram_icb_cmd_read,
    output logic [63:0]   biu2iram_icb_cmd_wdata,
    output logic [7:0]    biu2iram_icb_cmd_wmask,
    input  logic          biu2iram_icb_rsp_valid,
    output logic          biu2iram_icb_rsp_ready,
    input  logic          biu2iram_icb_rsp_err,
    input  logic [63:0]   biu2iram_icb_rsp_rdata,

    // DRAM port
    output logic          biu2dram_icb_cmd_valid,
    input  logic          biu2dram_icb_cmd_ready,
    output logic [15:0]   biu2dram_icb_cmd_addr,
    output logic          biu2dram_icb_cmd_read,
    output logic [63:0]   biu2dram_icb_cmd_wdata,
    output logic [7:0]    biu2dram_icb_cmd_wmask,
    input  logic          biu2dram_icb_rsp_valid,
    output logic          biu2dram_icb_rsp_ready,
    input  logic          biu2dram_icb_rsp_err,
    input  logic [63:0]   biu2dram_icb_rsp_rdata
);

    logic      hit_i;
    logic      hit_d;
    logic      cmd_ok;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    dest_tag_t push_tag;
    dest_tag_t head_tag;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign hit_i    = (i_icb_cmd_addr[AW-1:RAM_WIN_AW] == IRAM_BASE[AW-1:RAM_WIN_AW]);
    assign hit_d    = (i_icb_cmd_addr[AW-1:RAM_WIN_AW] == DRAM_BASE[AW-1:RAM_WIN_AW]);
    assign push_tag = decode_dest(hit_i, hit_d);

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    // A command may only be issued while a FIFO slot is free. Reset gates
    // the handshake directly so nothing is issued or accepted while rst_n
    // is held low, even if the master keeps its valid asserted. Full is the
    // registered occupancy, so no response-side signal reaches the ready path.
    assign cmd_ok = rst_n & ~fifo_full;

    assign biu2iram_icb_cmd_valid = i_icb_cmd_valid & hit_i & cmd_ok;
    assign biu2dram_icb_cmd_valid = i_icb_cmd_valid & hit_d & cmd_ok;

    assign i_icb_cmd_ready = cmd_ok & (hit_i ? biu2iram_icb_cmd_ready :
                                       hit_d ? biu2dram_icb_cmd_ready : 1'b1);

    // Payload passes through unchanged; only the in-window offset is forwarded.
    assign biu2iram_icb_cmd_addr  = i_icb_cmd_addr[RAM_WIN_AW-1:0];
    assign biu2iram_icb_cmd_read  = i_icb_cmd_read;
    assign biu2iram_icb_cmd_wdata = i_icb_cmd_wdata;
    assign biu2iram_icb_cmd_wmask = i_icb_cmd_wmask;

    assign biu2dram_icb_cmd_addr  = i_icb_cmd_addr[RAM_WIN_AW-1:0];
    assign biu2dram_icb_cmd_read  = i_icb_cmd_read;
    assign biu2dram_icb_cmd_wdata = i_icb_cmd_wdata;
    assign biu2dram_icb_cmd_wmask = i_icb_cmd_wmask;

    // ------------------------------------------------------------------
    // Outstanding FIFO
    // ------------------------------------------------------------------
    assign push = i_icb_cmd_valid & i_icb_cmd_ready;
    assign pop  = i_icb_rsp_valid & i_icb_rsp_ready;

    e603_subsys_ram_outs_fifo #(
        .WIDTH (2),
        .DEPTH (OUTS_NUM),
        .CNT_W (OUTS_CNT_W)
    ) u_outs_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_tag),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_tag)
    );

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    // Route the response of the head destination to the master; every other
    // destination sees rsp_ready low and waits its turn.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        i_icb_rsp_valid        = 1'b0;
        i_icb_rsp_err          = 1'b0;
        i_icb_rsp_rdata        = '0;
        biu2iram_icb_rsp_ready = 1'b0;
        biu2dram_icb_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            case (head_tag)
                TAG_IRAM: begin
                    i_icb_rsp_valid        = biu2iram_icb_rsp_valid;
                    i_icb_rsp_err          = biu2iram_icb_rsp_err;
                    i_icb_rsp_rdata        = biu2iram_icb_rsp_rdata;
                    biu2iram_icb_rsp_ready = i_icb_rsp_ready;
                end
                TAG_DRAM: begin
                    i_icb_rsp_valid        = biu2dram_icb_rsp_valid;
                    i_icb_rsp_err          = biu2dram_icb_rsp_err;
                    i_icb_rsp_rdata        = biu2dram_icb_rsp_rdata;
                    biu2dram_icb_rsp_ready = i_icb_rsp_ready;
                end
                default: begin
                    // Unmapped command: answer locally with an error and no data.
                    i_icb_rsp_valid = 1'b1;
                    i_icb_rsp_err   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e603_subsys_ram_icb1to2_split.sv
// Self-checking bench for the ICB 1-to-2 splitter. Two behavioural RAM
// slaves answer with a value derived from the forwarded command; a
// reference model keeps the expected responses of all accepted commands
// in a queue in command order and predicts handshakes each cycle.
module tb_e603_subsys_ram_icb1to2_split;
    import e603_subsys_ram_icb1to2_split_pkg::*;

    typedef struct { logic [31:0] addr; logic read; logic [63:0] wdata; logic [7:0] wmask; } cmd_t;
    typedef struct { logic [63:0] rdata; logic err; int avail; } srsp_t;
    typedef struct { logic [1:0] dst; logic [63:0] rdata; logic err; } exp_t;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_cv, m_cr, m_rd, m_rv, m_rr, m_re;
    logic [31:0] m_addr;
    logic [63:0] m_wd, m_rdata;
    logic [7:0]  m_wm;
    logic        i_cv, i_cr, i_crd, i_rv, i_rr, i_re;
    logic [15:0] i_ca;
    logic [63:0] i_cwd, i_rd;
    logic [7:0]  i_cwm;
    logic        d_cv, d_cr, d_crd, d_rv, d_rr, d_re;
    logic [15:0] d_ca;
    logic [63:0] d_cwd, d_rd;
    logic [7:0]  d_cwm;

    e603_subsys_ram_icb1to2_split dut (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(m_cv), .i_icb_cmd_ready(m_cr), .i_icb_cmd_addr(m_addr),
        .i_icb_cmd_read(m_rd), .i_icb_cmd_wdata(m_wd), .i_icb_cmd_wmask(m_wm),
        .i_icb_rsp_valid(m_rv), .i_icb_rsp_ready(m_rr), .i_icb_rsp_err(m_re), .i_icb_rsp_rdata(m_rdata),
        .biu2iram_icb_cmd_valid(i_cv), .biu2iram_icb_cmd_ready(i_cr), .biu2iram_icb_cmd_addr(i_ca),
        .biu2iram_icb_cmd_read(i_crd), .biu2iram_icb_cmd_wdata(i_cwd), .biu2iram_icb_cmd_wmask(i_cwm),
        .biu2iram_icb_rsp_valid(i_rv), .biu2iram_icb_rsp_ready(i_rr), .biu2iram_icb_rsp_err(i_re),
        .biu2iram_icb_rsp_rdata(i_rd),
        .biu2dram_icb_cmd_valid(d_cv), .biu2dram_icb_cmd_ready(d_cr), .biu2dram_icb_cmd_addr(d_ca),
        .biu2dram_icb_cmd_read(d_crd), .biu2dram_icb_cmd_wdata(d_cwd), .biu2dram_icb_cmd_wmask(d_cwm),
        .biu2dram_icb_rsp_valid(d_rv), .biu2dram_icb_rsp_ready(d_rr), .biu2dram_icb_rsp_err(d_re),
        .biu2dram_icb_rsp_rdata(d_rd)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    cmd_t        dir_q[$];
    srsp_t       iq[$];
    srsp_t       dq[$];
    exp_t        mq[$];
    logic [1:0]  pop_log[$];
    bit          rand_en = 0, s_rdy_rand = 0, hold_i = 0, m_hs_last = 0;
    bit          force_i_en = 0, dram_held_seen = 0;
    logic [63:0] force_i_data = '0;
    int          rsp_rdy_mode = 0;
    int          lat_i_min = 1, lat_i_max = 1, lat_d_min = 1, lat_d_max = 1;
    int          m_acc_cnt = 0, i_acc_cnt = 0, d_acc_cnt = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [15:0] last_i_addr = '0, last_d_addr = '0;
    logic [7:0]  last_d_wmask = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Window decode straight from the memory map.
    function automatic logic [1:0] ref_dst(input logic [31:0] a);
        if (a[31:16] == 16'h8000) return TAG_IRAM;
        if (a[31:16] == 16'h9000) return TAG_DRAM;
        return TAG_ERR;
    endfunction

    // Response a RAM slave returns for a command: {err, rdata}.
    function automatic logic [64:0] slave_rsp(input logic is_d, input logic [15:0] a,
                                              input logic [63:0] wd, input logic rd);
        logic [63:0] r;
        r = {wd[47:0], a} ^ (is_d ? 64'h5A5A_0F0F_A5A5_F0F0 : 64'h3C3C_9696_C3C3_6969) ^ {63'd0, rd};
        return {(a[15:13] == 3'b011), r};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t        c;
        int          sel;
        logic [15:0] lo;
        sel = $urandom_range(9, 0);
        lo  = 16'($urandom);
        if (sel < 4)       c.addr = {16'h8000, lo};
        else if (sel < 8)  c.addr = {16'h9000, lo};
        else if (sel == 8) c.addr = {($urandom_range(1, 0) == 1) ? 16'h8001 : 16'h8FFF, lo};
        else               c.addr = {16'hA000, lo};
        c.read  = 1'($urandom_range(1, 0));
        c.wdata = {$urandom, $urandom};
        c.wmask = 8'($urandom);
        return c;
    endfunction

    // One clock: drive at the falling edge, sample and check 1 time unit before the rising edge.
    task automatic cycle();
        cmd_t        c;
        exp_t        e;
        srsp_t       s;
        logic [1:0]  dst;
        logic [64:0] r;
        bit          exp_full;
        logic        exp_cr, exp_rv, exp_irr, exp_drr;
        @(negedge clk);
        cyc++;
        if (m_hs_last) begin
            m_cv = 1'b0;
            m_hs_last = 1'b0;
        end
        if (!m_cv && (dir_q.size() > 0 || (rand_en && $urandom_range(3, 0) != 0))) begin
            if (dir_q.size() > 0) c = dir_q.pop_front();
            else c = rand_cmd();
            m_addr = c.addr; m_rd = c.read; m_wd = c.wdata; m_wm = c.wmask; m_cv = 1'b1;
        end
        m_rr = (rsp_rdy_mode == 0) ? 1'b1 : (rsp_rdy_mode == 1) ? ($urandom_range(3, 0) != 0) : 1'b0;
        i_cr = s_rdy_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
        d_cr = s_rdy_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
        if (!hold_i && iq.size() > 0 && iq[0].avail <= cyc) begin
            i_rv = 1'b1; i_re = iq[0].err; i_rd = iq[0].rdata;
        end else begin
            i_rv = 1'b0; i_re = 1'b0; i_rd = '0;
        end
        if (dq.size() > 0 && dq[0].avail <= cyc) begin
            d_rv = 1'b1; d_re = dq[0].err; d_rd = dq[0].rdata;
        end else begin
            d_rv = 1'b0; d_re = 1'b0; d_rd = '0;
        end
        #4;
        // Command side: a free slot is needed, then the addressed port's ready.
        dst      = ref_dst(m_addr);
        exp_full = (mq.size() >= DEPTH);
        exp_cr   = !exp_full && ((dst == TAG_IRAM) ? i_cr : (dst == TAG_DRAM) ? d_cr : 1'b1);
        check("cmd_ready", m_cr, exp_cr);
        check("iram_cmd_valid", i_cv, m_cv && dst == TAG_IRAM && !exp_full);
        check("dram_cmd_valid", d_cv, m_cv && dst == TAG_DRAM && !exp_full);
        // Response side: only the oldest outstanding command may answer.
        exp_rv = 1'b0; exp_irr = 1'b0; exp_drr = 1'b0;
        if (mq.size() > 0) begin
            if (mq[0].dst == TAG_IRAM) begin exp_rv = i_rv; exp_irr = m_rr; end
            else if (mq[0].dst == TAG_DRAM) begin exp_rv = d_rv; exp_drr = m_rr; end
            else exp_rv = 1'b1;
        end
        check("rsp_valid", m_rv, exp_rv);
        check("iram_rsp_ready", i_rr, exp_irr);
        check("dram_rsp_ready", d_rr, exp_drr);
        if (d_rv && !d_rr) dram_held_seen = 1;
        if (m_rv && m_rr) begin
            if (mq.size() == 0) check("rsp_on_empty", m_rv, 1'b0);
            else begin
                e = mq.pop_front();
                check("rsp_err", m_re, e.err);
                check("rsp_rdata", m_rdata, e.rdata);
                pop_log.push_back(e.dst);
                last_rdata = m_rdata; last_err = m_re; last_rsp_cyc = cyc;
            end
        end
        if (i_rv && i_rr) s = iq.pop_front();
        if (d_rv && d_rr) s = dq.pop_front();
        if (i_cv && i_cr) begin
            check("iram_fwd_addr", i_ca, m_addr[15:0]);
            check("iram_fwd_read", i_crd, m_rd);
            check("iram_fwd_wdata", i_cwd, m_wd);
            check("iram_fwd_wmask", i_cwm, m_wm);
            r = force_i_en ? {1'b0, force_i_data} : slave_rsp(1'b0, i_ca, i_cwd, i_crd);
            s.err = r[64]; s.rdata = r[63:0];
            s.avail = cyc + int'($urandom_range(lat_i_max, lat_i_min));
            iq.push_back(s);
            i_acc_cnt++; last_i_addr = i_ca;
        end
        if (d_cv && d_cr) begin
            check("dram_fwd_addr", d_ca, m_addr[15:0]);
            check("dram_fwd_read", d_crd, m_rd);
            check("dram_fwd_wdata", d_cwd, m_wd);
            check("dram_fwd_wmask", d_cwm, m_wm);
            r = slave_rsp(1'b1, d_ca, d_cwd, d_crd);
            s.err = r[64]; s.rdata = r[63:0];
            s.avail = cyc + int'($urandom_range(lat_d_max, lat_d_min));
            dq.push_back(s);
            d_acc_cnt++; last_d_addr = d_ca; last_d_wmask = d_cwm;
        end
        if (m_cv && m_cr) begin
            e.dst = dst;
            if (dst == TAG_ERR) r = {1'b1, 64'd0};
            else if (dst == TAG_IRAM && force_i_en) r = {1'b0, force_i_data};
            else r = slave_rsp(dst == TAG_DRAM, m_addr[15:0], m_wd, m_rd);
            e.err = r[64]; e.rdata = r[63:0];
            mq.push_back(e);
            m_hs_last = 1'b1; m_acc_cnt++; last_acc_cyc = cyc;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() > 0 || dir_q.size() > 0 || (m_cv && !m_hs_last)) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", (mq.size() == 0 && dir_q.size() == 0 && !(m_cv && !m_hs_last)), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int          m0, i0, d0, n, pcyc;
        logic [64:0] r;
        m_cv = 0; m_addr = '0; m_rd = 0; m_wd = '0; m_wm = '0; m_rr = 0;
        i_cr = 0; i_rv = 0; i_re = 0; i_rd = '0;
        d_cr = 0; d_rv = 0; d_re = 0; d_rd = '0;

        // Reset: nothing issued or accepted while rst_n is low, even with a live command.
        repeat (2) @(negedge clk);
        m_cv = 1; m_addr = 32'h8000_0000; m_rd = 1; m_rr = 1; i_cr = 1; d_cr = 1;
        #4;
        check("rst_cmd_ready", m_cr, 1'b0);
        check("rst_iram_cmd_valid", i_cv, 1'b0);
        check("rst_dram_cmd_valid", d_cv, 1'b0);
        check("rst_rsp_valid", m_rv, 1'b0);
        check("rst_iram_rsp_ready", i_rr, 1'b0);
        check("rst_dram_rsp_ready", d_rr, 1'b0);
        @(negedge clk);
        m_cv = 0;
        rst_n = 1;

        // Single IRAM read with a fixed response value.
        force_i_en = 1; force_i_data = 64'hDEAD_BEEF_0123_4567;
        d0 = d_acc_cnt;
        dir_q.push_back('{32'h8000_0010, 1'b1, 64'h0, 8'hFF});
        drain(50);
        force_i_en = 0;
        check("t1_iram_addr", last_i_addr, 16'h0010);
        check("t1_rdata", last_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t1_err", last_err, 1'b0);
        check("t1_dram_idle", d_acc_cnt, d0);

        // DRAM write at the top of the window.
        dir_q.push_back('{32'h9000_FFF8, 1'b0, 64'h1122_3344_5566_7788, 8'h0F});
        drain(50);
        check("t2_addr", last_d_addr, 16'hFFF8);
        check("t2_wmask", last_d_wmask, 8'h0F);
        check("t2_err", last_err, 1'b0);

        // Unmapped read: local error one cycle after acceptance, no downstream traffic.
        i0 = i_acc_cnt; d0 = d_acc_cnt;
        dir_q.push_back('{32'hA000_0000, 1'b1, 64'h0, 8'hFF});
        drain(50);
        check("t3_latency", last_rsp_cyc - last_acc_cyc, 1);
        check("t3_err", last_err, 1'b1);
        check("t3_rdata", last_rdata, 64'd0);
        check("t3_no_downstream", i_acc_cnt + d_acc_cnt, i0 + d0);

        // Ordering: DRAM answers first but must wait behind the older IRAM command.
        lat_i_min = 6; lat_i_max = 6; lat_d_min = 1; lat_d_max = 1;
        pop_log.delete(); dram_held_seen = 0;
        dir_q.push_back('{32'h8000_0100, 1'b1, 64'h0, 8'hFF});
        dir_q.push_back('{32'h9000_0200, 1'b1, 64'h0, 8'hFF});
        dir_q.push_back('{32'h8000_0300, 1'b1, 64'h0, 8'hFF});
        drain(100);
        check("t4_count", pop_log.size(), 3);
        check("t4_order", {pop_log[0], pop_log[1], pop_log[2]}, {TAG_IRAM, TAG_DRAM, TAG_IRAM});
        check("t4_dram_held", dram_held_seen, 1'b1);
        lat_i_min = 1; lat_i_max = 1;

        // Fill: IRAM stalls, the fifth command waits until a slot frees.
        hold_i = 1; m0 = m_acc_cnt;
        for (int k = 0; k < 5; k++) dir_q.push_back('{32'h8000_1000 + 32'(k * 8), 1'b1, 64'h0, 8'hFF});
        repeat (10) cycle();
        check("t5_accepted", m_acc_cnt - m0, 4);
        check("t5_cmd_ready_low", m_cr, 1'b0);
        hold_i = 0; pop_log.delete(); n = 0;
        while (pop_log.size() == 0 && n < 50) begin cycle(); n++; end
        pcyc = last_rsp_cyc;
        drain(100);
        check("t5_all_accepted", m_acc_cnt - m0, 5);
        check("t5_ready_return", last_acc_cyc - pcyc, 1);

        // Reset with three commands outstanding.
        rsp_rdy_mode = 2; m0 = m_acc_cnt; n = 0;
        dir_q.push_back('{32'hA000_0040, 1'b1, 64'h0, 8'hFF});
        dir_q.push_back('{32'h8000_0008, 1'b1, 64'h0, 8'hFF});
        dir_q.push_back('{32'h9000_0010, 1'b1, 64'h0, 8'hFF});
        while (m_acc_cnt - m0 < 3 && n < 20) begin cycle(); n++; end
        check("t6_three_out", m_acc_cnt - m0, 3);
        @(negedge clk);
        m_cv = 1; m_addr = 32'h8000_0020; m_rd = 1; m_hs_last = 0; i_cr = 1; d_cr = 1;
        m_rr = 0; i_rv = 0; d_rv = 0;
        #2;
        check("t6_pre_rsp_valid", m_rv, 1'b1);
        check("t6_pre_cmd_valid", i_cv, 1'b1);
        rst_n = 0;
        #1;
        check("t6_rst_rsp_valid", m_rv, 1'b0);
        check("t6_rst_iram_cmd_valid", i_cv, 1'b0);
        check("t6_rst_dram_cmd_valid", d_cv, 1'b0);
        check("t6_rst_cmd_ready", m_cr, 1'b0);
        repeat (2) @(negedge clk);
        m_cv = 0; mq.delete(); iq.delete(); dq.delete(); rst_n = 1; rsp_rdy_mode = 0;
        #4;
        check("t6_post_rsp_valid", m_rv, 1'b0);
        check("t6_post_cmd_ready", m_cr, 1'b1);
        dir_q.push_back('{32'h8000_0000, 1'b1, 64'h0000_0000_CAFE_0000, 8'hFF});
        drain(50);
        r = slave_rsp(1'b0, 16'h0000, 64'h0000_0000_CAFE_0000, 1'b1);
        check("t6_new_read_rdata", last_rdata, r[63:0]);

        // Randomised traffic with random latencies and back-pressure on every side.
        rand_en = 1; s_rdy_rand = 1; rsp_rdy_mode = 1;
        lat_i_min = 1; lat_i_max = 4; lat_d_min = 1; lat_d_max = 4;
        repeat (1500) cycle();
        rand_en = 0;
        drain(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
